// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell and a registered carry.
// done pulses WIDTH+1 cycles after start is accepted; start is ignored while busy.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_nxt;

  assign s_bit = a_sr[0] ^ b_sr[0] ^ c;
  assign c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          // FIN accepts start exactly like IDLE so operations can run back-to-back
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum  <= {s_bit, sum[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          c    <= c_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // c is the carry into the MSB here, c_nxt the carry out of it
            cout  <= c_nxt;
            ovf   <= c ^ c_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
